// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl: 16550-style prioritised interrupt controller (LS, RDA, CTI, THRE) with sticky pending state.
module uart_irq_ctrl #(
  parameter int TX_FIFO_DEPTH = 32,
  parameter int RX_FIFO_DEPTH = 32,
  parameter int TIMEOUT_CHARS = 4,
  parameter int CNT_W         = 16
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [3:0]                       ier_i,
  input  logic                             error_i,
  input  logic [$clog2(RX_FIFO_DEPTH):0]   rx_elements_i,
  input  logic [$clog2(TX_FIFO_DEPTH):0]   tx_elements_i,
  input  logic [1:0]                       trigger_level_i,
  input  logic                             rx_push_i,
  input  logic                             rx_pop_i,
  input  logic                             iir_rd_i,
  input  logic                             lsr_rd_i,
  input  logic [CNT_W-1:0]                 char_time_i,
  output logic [3:0]                       pending_o,
  output logic [3:0]                       iir_o,
  output logic                             interrupt_o
);
  localparam int TW = CNT_W + $clog2(TIMEOUT_CHARS) + 1;
  logic [31:0]   thr_raw, thr;
  logic          rda_hit, cnt_rst, cti_hit, tx_empty, thre_set;
  logic [TW-1:0] cnt_q, cnt_d, cti_tgt;
  logic [3:0]    pend_q, pend_d, iir_q, iir_d;
  logic          tx_empty_q, thre_en_q, irq_q;
  assign thr_raw = trigger_level_i == 2'b00 ? 32'd1 :
                   trigger_level_i == 2'b01 ? 32'd4 :
                   trigger_level_i == 2'b10 ? 32'd8 : 32'd14;
  assign thr     = thr_raw > 32'(RX_FIFO_DEPTH) ? 32'(RX_FIFO_DEPTH) : thr_raw;
  assign rda_hit = 32'(rx_elements_i) >= thr;
  // Any RX activity, or an empty RX FIFO, restarts the character-timeout window.
  assign cnt_rst = rx_push_i | rx_pop_i | (rx_elements_i == '0);
  assign cnt_d   = cnt_rst ? '0 : (&cnt_q) ? cnt_q : cnt_q + TW'(1);
  assign cti_tgt = TW'(TIMEOUT_CHARS) * TW'(char_time_i) - TW'(1);
  assign cti_hit = ier_i[3] & (char_time_i != '0) & (cnt_q == cti_tgt);
  assign tx_empty = tx_elements_i == '0;
  assign thre_set = ier_i[1] & tx_empty & (~tx_empty_q | ~thre_en_q);
  assign pend_d[0] = ier_i[0] & rda_hit;
  assign pend_d[1] = ~ier_i[1] ? 1'b0 :
                     thre_set  ? 1'b1 :
                     ~tx_empty ? 1'b0 :
                     (iir_rd_i & (iir_q == 4'b0010)) ? 1'b0 : pend_q[1];
  assign pend_d[2] = ~ier_i[2] ? 1'b0 : error_i ? 1'b1 : lsr_rd_i ? 1'b0 : pend_q[2];
  assign pend_d[3] = (~ier_i[3] | cnt_rst) ? 1'b0 : cti_hit ? 1'b1 : pend_q[3];
  assign iir_d = pend_q[2] ? 4'b0110 :
                 pend_q[0] ? 4'b0100 :
                 pend_q[3] ? 4'b1100 :
                 pend_q[1] ? 4'b0010 : 4'b0001;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q      <= '0;
      pend_q     <= '0;
      iir_q      <= 4'b0001;
      irq_q      <= 1'b0;
      tx_empty_q <= 1'b1;
      thre_en_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      iir_q      <= iir_d;
      irq_q      <= ~iir_d[0];
      tx_empty_q <= tx_empty;
      thre_en_q  <= ier_i[1];
    end
  end
  assign pending_o   = pend_q;
  assign iir_o       = iir_q;
  assign interrupt_o = irq_q;
endmodule

// File: tb/tb_uart_irq_ctrl.sv
// tb_uart_irq_ctrl: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_uart_irq_ctrl;
  localparam int TOC = 4;
  logic        clk = 1'b0, rstn = 1'b0;
  logic [3:0]  ier = '0;
  logic        error = 1'b0, push = 1'b0, pop = 1'b0, iir_rd = 1'b0, lsr_rd = 1'b0;
  logic [5:0]  rx_el = '0, tx_el = '0;
  logic [3:0]  rx_el_s = '0, tx_el_s = '0;
  logic [1:0]  trig = '0;
  logic [15:0] ct = '0;
  logic [3:0]  pend, iir, pend_s, iir_s;
  logic        irq, irq_s;
  int tests = 0, fails = 0;
  bit [3:0] m_pend, m_iir;
  int  m_idle;
  bit  m_tx_was_empty, m_thre_en_was;

  uart_irq_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .ier_i(ier), .error_i(error),
    .rx_elements_i(rx_el), .tx_elements_i(tx_el), .trigger_level_i(trig),
    .rx_push_i(push), .rx_pop_i(pop), .iir_rd_i(iir_rd), .lsr_rd_i(lsr_rd),
    .char_time_i(ct), .pending_o(pend), .iir_o(iir), .interrupt_o(irq)
  );
  uart_irq_ctrl #(.TX_FIFO_DEPTH(8), .RX_FIFO_DEPTH(8)) dut_small (
    .clk_i(clk), .rstn_i(rstn), .ier_i(ier), .error_i(error),
    .rx_elements_i(rx_el_s), .tx_elements_i(tx_el_s), .trigger_level_i(trig),
    .rx_push_i(push), .rx_pop_i(pop), .iir_rd_i(iir_rd), .lsr_rd_i(lsr_rd),
    .char_time_i(ct), .pending_o(pend_s), .iir_o(iir_s), .interrupt_o(irq_s)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  function automatic bit [3:0] prio(input bit [3:0] p);
    if (p[2]) return 4'b0110;
    if (p[0]) return 4'b0100;
    if (p[3]) return 4'b1100;
    if (p[1]) return 4'b0010;
    return 4'b0001;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_iir = 4'b0001; m_idle = 0; m_tx_was_empty = 1; m_thre_en_was = 0;
  endtask

  // One clock of the interrupt rules, applied to the inputs present at the edge.
  task automatic model_step();
    int thr;
    bit [3:0] np;
    bit empty;
    thr = trig == 0 ? 1 : trig == 1 ? 4 : trig == 2 ? 8 : 14;
    if (thr > 32) thr = 32;
    empty = (tx_el == 0);
    np[0] = ier[0] && (int'(rx_el) >= thr);
    np[2] = ier[2] && (error || (m_pend[2] && !lsr_rd));
    if (!ier[1]) np[1] = 0;
    else if (empty && (!m_tx_was_empty || !m_thre_en_was)) np[1] = 1;
    else np[1] = m_pend[1] && empty && !(iir_rd && m_iir == 4'b0010);
    if (push || pop || rx_el == 0) begin
      m_idle = 0;
      np[3] = 0;
    end else begin
      m_idle++;
      np[3] = ier[3] && (m_pend[3] || (ct != 0 && m_idle == TOC * int'(ct)));
    end
    m_tx_was_empty = empty;
    m_thre_en_was = ier[1];
    m_iir = prio(m_pend);
    m_pend = np;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    error = 0; push = 0; pop = 0; iir_rd = 0; lsr_rd = 0;
  endtask

  task automatic push_char();
    push = 1; tick(); rx_el = rx_el + 6'd1;
  endtask

  task automatic pop_char();
    pop = 1; tick(); rx_el = rx_el - 6'd1;
  endtask

  task automatic do_reset();
    ier = '0; rx_el = '0; tx_el = '0; rx_el_s = '0; trig = '0; ct = '0;
    error = 0; push = 0; pop = 0; iir_rd = 0; lsr_rd = 0;
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (pend !== 4'b0000) begin fails++; $display("FAIL reset_pending: got %b exp 0000", pend); end
    tests++; if (iir !== 4'b0001) begin fails++; $display("FAIL reset_iir: got %b exp 0001", iir); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b exp 0", irq); end
    tick(); tick();
    tests++; if (iir !== 4'b0001) begin fails++; $display("FAIL reset_idle_iir: got %b exp 0001", iir); end
  endtask

  task automatic test_thre();
    do_reset();
    ier = 4'b0010;
    tick();
    tests++; if (pend !== 4'b0010) begin fails++; $display("FAIL thre_pending: got %b exp 0010", pend); end
    tests++; if (iir !== 4'b0001) begin fails++; $display("FAIL thre_iir_early: got %b exp 0001", iir); end
    tick();
    tests++; if (iir !== 4'b0010) begin fails++; $display("FAIL thre_iir: got %b exp 0010", iir); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL thre_irq: got %b exp 1", irq); end
    iir_rd = 1; tick();
    tests++; if (pend !== 4'b0000) begin fails++; $display("FAIL thre_iir_rd_clear: got %b exp 0000", pend); end
    tick();
    tests++; if (iir !== 4'b0001) begin fails++; $display("FAIL thre_iir_after_rd: got %b exp 0001", iir); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL thre_irq_after_rd: got %b exp 0", irq); end
    tx_el = 6'd5; tick(); tick();
    tests++; if (pend[1] !== 1'b0) begin fails++; $display("FAIL thre_nonempty: got %b exp 0", pend[1]); end
    tx_el = 6'd0; tick();
    tests++; if (pend[1] !== 1'b1) begin fails++; $display("FAIL thre_drain_set: got %b exp 1", pend[1]); end
  endtask

  task automatic test_rda();
    do_reset();
    ier = 4'b0001; trig = 2'b01;
    repeat (3) push_char();
    tick(); tick();
    tests++; if (pend[0] !== 1'b0) begin fails++; $display("FAIL rda_below: got %b exp 0", pend[0]); end
    tests++; if (iir !== 4'b0001) begin fails++; $display("FAIL rda_iir_3: got %b exp 0001", iir); end
    push_char(); tick();
    tests++; if (pend[0] !== 1'b1) begin fails++; $display("FAIL rda_at_trigger: got %b exp 1", pend[0]); end
    tick();
    tests++; if (iir !== 4'b0100) begin fails++; $display("FAIL rda_iir_4: got %b exp 0100", iir); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL rda_irq_4: got %b exp 1", irq); end
    push_char(); tick(); tick();
    tests++; if (iir !== 4'b0100) begin fails++; $display("FAIL rda_iir_5: got %b exp 0100", iir); end
    pop_char(); pop_char(); tick(); tick();
    tests++; if (iir !== 4'b0001) begin fails++; $display("FAIL rda_iir_popped: got %b exp 0001", iir); end
    trig = 2'b11; rx_el_s = 4'd7; tick(); tick();
    tests++; if (pend_s[0] !== 1'b0) begin fails++; $display("FAIL rda_clamp_below: got %b exp 0", pend_s[0]); end
    rx_el_s = 4'd8; tick();
    tests++; if (pend_s[0] !== 1'b1) begin fails++; $display("FAIL rda_clamp_at_depth: got %b exp 1", pend_s[0]); end
  endtask

  task automatic test_cti();
    do_reset();
    ier = 4'b1000; ct = 16'd10;
    push_char();
    repeat (39) tick();
    tests++; if (pend[3] !== 1'b0) begin fails++; $display("FAIL cti_early: got %b exp 0", pend[3]); end
    tick();
    tests++; if (pend[3] !== 1'b1) begin fails++; $display("FAIL cti_set: got %b exp 1", pend[3]); end
    tick();
    tests++; if (iir !== 4'b1100) begin fails++; $display("FAIL cti_iir: got %b exp 1100", iir); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL cti_irq: got %b exp 1", irq); end
    push_char();
    tests++; if (pend[3] !== 1'b0) begin fails++; $display("FAIL cti_push_clear: got %b exp 0", pend[3]); end
    do_reset();
    ier = 4'b1000; ct = 16'd10;
    push_char(); push_char();
    repeat (38) tick();
    pop_char();
    repeat (39) tick();
    tests++; if (pend[3] !== 1'b0) begin fails++; $display("FAIL cti_pop_prevents: got %b exp 0", pend[3]); end
    tick();
    tests++; if (pend[3] !== 1'b1) begin fails++; $display("FAIL cti_after_pop: got %b exp 1", pend[3]); end
  endtask

  task automatic test_priority();
    do_reset();
    ier = 4'b1111; trig = 2'b11; rx_el = 6'd14; error = 1;
    tick();
    tests++; if (pend !== 4'b0111) begin fails++; $display("FAIL prio_pending: got %b exp 0111", pend); end
    tick();
    tests++; if (iir !== 4'b0110) begin fails++; $display("FAIL prio_ls: got %b exp 0110", iir); end
    iir_rd = 1; tick();
    tests++; if (pend[1] !== 1'b1) begin fails++; $display("FAIL prio_thre_kept: got %b exp 1", pend[1]); end
    lsr_rd = 1; tick();
    tests++; if (pend !== 4'b0011) begin fails++; $display("FAIL prio_lsr_clear: got %b exp 0011", pend); end
    tick();
    tests++; if (iir !== 4'b0100) begin fails++; $display("FAIL prio_rda: got %b exp 0100", iir); end
    pop_char(); tick(); tick();
    tests++; if (iir !== 4'b0010) begin fails++; $display("FAIL prio_thre: got %b exp 0010", iir); end
    tx_el = 6'd1; tick();
    tx_el = 6'd0; iir_rd = 1; tick();
    tests++; if (pend[1] !== 1'b1) begin fails++; $display("FAIL prio_thre_set_wins: got %b exp 1", pend[1]); end
  endtask

  task automatic test_ls_reset();
    do_reset();
    ier = 4'b0100; error = 1; tick();
    tests++; if (pend !== 4'b0100) begin fails++; $display("FAIL ls_set: got %b exp 0100", pend); end
    error = 1; lsr_rd = 1; tick();
    tests++; if (pend[2] !== 1'b1) begin fails++; $display("FAIL ls_set_wins: got %b exp 1", pend[2]); end
    tick();
    tests++; if (iir !== 4'b0110) begin fails++; $display("FAIL ls_iir: got %b exp 0110", iir); end
    ier = 4'b1100; ct = 16'd10;
    push_char();
    repeat (20) tick();
    rstn = 0; #1;
    tests++; if (pend !== 4'b0000) begin fails++; $display("FAIL async_pending: got %b exp 0000", pend); end
    tests++; if (iir !== 4'b0001) begin fails++; $display("FAIL async_iir: got %b exp 0001", iir); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL async_irq: got %b exp 0", irq); end
    @(posedge clk); #1;
    rstn = 1; model_reset();
    repeat (39) tick();
    tests++; if (pend[3] !== 1'b0) begin fails++; $display("FAIL async_cnt_cleared: got %b exp 0", pend[3]); end
    tick();
    tests++; if (pend[3] !== 1'b1) begin fails++; $display("FAIL async_cnt_restart: got %b exp 1", pend[3]); end
  endtask

  task automatic test_cti_disable();
    bit seen = 0;
    do_reset();
    ier = 4'b1000; ct = 16'd0;
    push_char(); push_char();
    for (int i = 0; i < 10000; i++) begin
      tick();
      seen |= pend[3];
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL cti_disabled: got %b exp 0", seen); end
    tests++; if (iir !== 4'b0001) begin fails++; $display("FAIL cti_disabled_iir: got %b exp 0001", iir); end
    ier = 4'b1100; error = 1; tick();
    tests++; if (pend[2] !== 1'b1) begin fails++; $display("FAIL ier_ls_set: got %b exp 1", pend[2]); end
    ier = 4'b1000; tick();
    tests++; if (pend[2] !== 1'b0) begin fails++; $display("FAIL ier_ls_clear: got %b exp 0", pend[2]); end
  endtask

  task automatic test_random();
    bit p, q;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) ier = 4'($urandom);
      if ($urandom_range(0, 99) == 0) trig = 2'($urandom);
      if ($urandom_range(0, 99) == 0) ct = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) tx_el = $urandom_range(0, 2) == 0 ? 6'd0 : 6'($urandom_range(1, 32));
      error  = $urandom_range(0, 19) == 0;
      push   = rx_el < 6'd32 && $urandom_range(0, 9) == 0;
      pop    = rx_el > 6'd0 && $urandom_range(0, 11) == 0;
      iir_rd = $urandom_range(0, 7) == 0;
      lsr_rd = $urandom_range(0, 9) == 0;
      p = push; q = pop;
      tick();
      rx_el = rx_el + 6'(p) - 6'(q);
      tests++; if (pend !== m_pend) begin fails++; $display("FAIL rand_pending[%0d]: got %b exp %b", i, pend, m_pend); end
      tests++; if (iir !== m_iir) begin fails++; $display("FAIL rand_iir[%0d]: got %b exp %b", i, iir, m_iir); end
      tests++; if (irq !== (m_iir != 4'b0001)) begin fails++; $display("FAIL rand_irq[%0d]: got %b exp %b", i, irq, m_iir != 4'b0001); end
    end
  endtask

  initial begin
    test_reset();
    test_thre();
    test_rda();
    test_cti();
    test_priority();
    test_ls_reset();
    test_cti_disable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_irq_ctrl.md
Name: uart_irq_ctrl

Overview:
- Second-generation UART interrupt controller with four prioritised sources:
  - line status (LS)
  - RX data available (RDA)
  - character timeout (CTI)
  - TX holding empty (THRE)
- Sticky, per-source pending state with 16550-style clear-on-access semantics.
- Parametrised FIFO depths; programmable character-time timeout counter.
- Sits between the UART RX/TX FIFOs, the register-file decode, and the SoC PLIC line.

Parameters:
- TX_FIFO_DEPTH, 32, TX FIFO entries; tx_elements_i width = $clog2(TX_FIFO_DEPTH)+1.
- RX_FIFO_DEPTH, 32, RX FIFO entries; rx_elements_i width = $clog2(RX_FIFO_DEPTH)+1.
- TIMEOUT_CHARS, 4, number of character times of RX inactivity that raises CTI.
- CNT_W, 16, width of char_time_i (clock cycles per character frame).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- ier_i  in  4  enables: [0] RDA, [1] THRE, [2] LS, [3] CTI.
- error_i  in  1  RX parity/framing/overrun error pulse.
- rx_elements_i  in  $clog2(RX_FIFO_DEPTH)+1  RX FIFO fill level.
- tx_elements_i  in  $clog2(TX_FIFO_DEPTH)+1  TX FIFO fill level.
- trigger_level_i  in  2  RX trigger select.
- rx_push_i  in  1  one-cycle pulse: character written into RX FIFO.
- rx_pop_i  in  1  one-cycle pulse: RBR read by host.
- iir_rd_i  in  1  one-cycle pulse: IIR read by host.
- lsr_rd_i  in  1  one-cycle pulse: LSR read by host.
- char_time_i  in  CNT_W  cycles per character; 0 disables CTI.
- pending_o  out  4  registered pending vector, same bit order as ier_i.
- iir_o  out  4  registered interrupt identification.
- interrupt_o  out  1  registered; equals ~iir_o[0].

Behaviour:
- Reset values: pending_o=0, iir_o=4'b0001, interrupt_o=0, timeout counter=0, tx_empty_q=1.
- Trigger threshold by trigger_level_i:
  - 00 -> 1; 01 -> 4; 10 -> 8; 11 -> 14.
  - Threshold is clamped to RX_FIFO_DEPTH when larger.
- LS pending:
  - Set on error_i & ier_i[2]; cleared on lsr_rd_i.
  - error_i and lsr_rd_i in the same cycle: set wins.
- RDA pending: level-sensitive, registered; = ier_i[0] & (rx_elements_i >= threshold).
  - Uses >= (not ==), so the flag stays asserted above the trigger level.
- CTI counter:
  - Counter width CNT_W+$clog2(TIMEOUT_CHARS)+1; saturating.
  - Resets to 0 on rx_push_i, on rx_pop_i, or while rx_elements_i==0.
  - Otherwise increments each cycle.
- CTI pending:
  - Set when ier_i[3] & char_time_i!=0 & counter == TIMEOUT_CHARS*char_time_i-1.
  - Cleared by any counter-reset condition.
  - Never set while rx_elements_i==0.
- THRE pending:
  - tx_empty_q registers (tx_elements_i==0).
  - Set on a rising edge of empty (1 after 0) while ier_i[1]=1.
  - Set when ier_i[1] rises while the TX FIFO is empty.
  - Cleared when tx_elements_i becomes nonzero.
  - Cleared by iir_rd_i only if iir_o currently reports 4'b0010.
  - Set event in the same cycle as iir_rd_i: set wins.
- Enable interaction: clearing an ier_i bit clears that pending bit on the next clock; it is not retained.
- Priority (highest first), encoded into iir_o:
  - LS -> 4'b0110
  - RDA -> 4'b0100
  - CTI -> 4'b1100
  - THRE -> 4'b0010
  - none -> 4'b0001
- Latency:
  - Source event to pending_o: 1 cycle.
  - pending_o to iir_o/interrupt_o: 1 more cycle (2 cycles total).
- iir_o is recomputed every cycle from pending. After a clear, the next-highest pending source appears on the following cycle.
- Reset mid-operation: all state returns to reset values asynchronously. No pending state survives.

Test Plan:
- Reset, ier_i=4'b0010, TX empty -> THRE pending; iir_o=4'b0010 and interrupt_o=1 two cycles after ier_i write. One iir_rd_i pulse -> iir_o=4'b0001 two cycles later.
- ier_i=4'b0001, trigger_level_i=01, push 3 then 4 chars -> iir_o stays 0001 at 3 chars; becomes 0100 at 4 chars. Holds at 5 chars; returns to 0001 after popping down to 3.
- ier_i=4'b1000, char_time_i=10, TIMEOUT_CHARS=4, single rx_push_i -> iir_o=4'b1100 at cycle 40+1 after the push. An rx_pop_i at cycle 39 instead prevents it.
- ier_i=4'b1111, simultaneous error_i, 14 RX chars, TX empty -> iir_o=0110. After lsr_rd_i -> 0100. After popping below threshold -> 0010 (THRE still pending).
- error_i and lsr_rd_i in the same cycle -> LS remains pending, iir_o=0110. Assert rstn_i=0 mid-timeout count -> pending_o=0, iir_o=0001, counter=0 immediately.
- char_time_i=0 with 2 chars idle for 10000 cycles -> CTI never set. ier_i[2] cleared while LS pending -> pending_o[2]=0 next cycle.
